// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit bridging RV32I-style requests to a word-wide
// data memory with one-cycle read latency; sub-word stores use read-modify-write.
module load_store_unit #(
  parameter int WORD_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_error,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  output logic                mem_wen,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic [2:0]          dbg_state
);

  // Handshake: a request is taken on a rising edge where req_valid and
  // req_ready are both high; resp_valid is a single-cycle completion pulse.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t state, state_next;

  logic       wen_q;
  logic [2:0] funct3_q;
  logic [1:0] lo_q;
  logic       req_bad;

  function automatic logic bad_request(input logic wen, input logic [2:0] f3,
                                       input logic [1:0] lo);
    logic illegal, misaligned;
    illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                 (wen && f3[2]);
    misaligned = ((f3[1:0] == 2'b01) && lo[0]) ||
                 ((f3[1:0] == 2'b10) && (lo != 2'b00));
    return illegal || misaligned;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Store data sits in mem_wdata from accept; its low bits feed the merge.
  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [1:0] lo,
                                              input logic [31:0] word,
                                              input logic [31:0] data);
    logic [31:0] m;
    m = word;
    if (!f3[0])
      m[{lo, 3'b000} +: 8] = data[7:0];
    else if (lo[1])
      m[31:16] = data[15:0];
    else
      m[15:0] = data[15:0];
    return m;
  endfunction

  assign req_bad = bad_request(req_wen, req_funct3, req_addr[1:0]);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)
            state_next = RESP;
          else if (req_wen && (req_funct3 == 3'b010))
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ:    state_next = CAPTURE;
      CAPTURE: state_next = wen_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wen_q      <= 1'b0;
      funct3_q   <= 3'd0;
      lo_q       <= 2'd0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wen_q    <= req_wen;
            funct3_q <= req_funct3;
            lo_q     <= req_addr[1:0];
            mem_addr <= {req_addr[WORD_LEN-1:2], 2'b00};
            if (req_bad) begin
              resp_rdata <= '0;
              resp_error <= 1'b1;
            end else if (req_wen) begin
              mem_wdata <= req_wdata;
            end
          end
        end
        CAPTURE: begin
          if (wen_q) begin
            mem_wdata <= store_merge(funct3_q, lo_q, mem_rdata, mem_wdata);
          end else begin
            resp_rdata <= load_extract(funct3_q, lo_q, mem_rdata);
            resp_error <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata <= '0;
          resp_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign mem_wen    = (state == WRITE);
  assign resp_valid = (state == RESP);
  assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a
// response scoreboard.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  // memory model
  logic [31:0] mem [0:255];
  logic        preload_en = 1'b0;
  logic [7:0]  preload_idx = 8'd0;
  logic [31:0] preload_val = 32'd0;
  int          write_cnt = 0;
  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;

  load_store_unit #(.WORD_LEN(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (preload_en) begin
      mem[preload_idx] <= preload_val;
    end else if (mem_wen) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      write_cnt  <= write_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clock);
    preload_en  = 1'b1;
    preload_idx = addr[9:2];
    preload_val = val;
    @(posedge clock);
    #1 preload_en = 1'b0;
  endtask

  task automatic drive_req(input logic wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clock);
    check("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clock);
    #1;
    req_valid  = 1'b0;
    req_wdata  = 32'hFFFF_FFFF;
    req_addr   = 32'hFFFF_FFFF;
  endtask

  task automatic do_req(input string tag, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_writes,
                        input logic [31:0] exp_waddr, input logic [31:0] exp_wdata);
    int wr0, lat;
    logic [31:0] e_rd;
    logic        e_err;
    exp_q.push_back(exp_rdata);
    exp_err_q.push_back(exp_err);
    wr0 = write_cnt;
    drive_req(wen, f3, addr, wdata);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    e_rd  = exp_q.pop_front();
    e_err = exp_err_q.pop_front();
    check({tag, "_rdata"}, resp_rdata, e_rd);
    check({tag, "_error"}, {31'd0, resp_error}, {31'd0, e_err});
    check({tag, "_writes"}, write_cnt - wr0, exp_writes);
    if (exp_writes == 1) begin
      check({tag, "_waddr"}, last_waddr, exp_waddr);
      check({tag, "_wdata"}, last_wdata, exp_wdata);
    end
    @(negedge clock);
    check({tag, "_pulse_end"}, {30'd0, resp_valid, req_ready}, 32'd1);
    check({tag, "_hold"}, resp_rdata, e_rd);
  endtask

  initial begin
    logic [31:0] a, d;
    int w0;
    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    check("rst_ready",  {31'd0, req_ready},  32'd1);
    check("rst_wen",    {31'd0, mem_wen},    32'd0);
    check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst_rerror", {31'd0, resp_error}, 32'd0);
    check("rst_maddr",  mem_addr,  32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    check("rst_rdata",  resp_rdata, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_outs", {27'd0, req_ready, mem_wen, resp_valid, resp_error, 1'b0}, 32'h10);
    check("post_rst_data", mem_addr | mem_wdata | resp_rdata, 32'd0);

    do_req("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 32'h100, 32'hDEADBEEF);
    set_word(32'h100, 32'h11223344);
    do_req("sb", 1'b1, 3'b000, 32'h103, 32'h000000AA, 32'd0, 1'b0, 4, 1, 32'h100, 32'hAA223344);
    set_word(32'h100, 32'h11803344);
    do_req("lb",  1'b0, 3'b000, 32'h102, 32'd0, 32'hFFFFFF80, 1'b0, 3, 0, 32'd0, 32'd0);
    do_req("lbu", 1'b0, 3'b100, 32'h102, 32'd0, 32'h00000080, 1'b0, 3, 0, 32'd0, 32'd0);
    do_req("lh",  1'b0, 3'b001, 32'h102, 32'd0, 32'h00001180, 1'b0, 3, 0, 32'd0, 32'd0);
    do_req("lw",  1'b0, 3'b010, 32'h100, 32'd0, 32'h11803344, 1'b0, 3, 0, 32'd0, 32'd0);
    do_req("lhu", 1'b0, 3'b101, 32'h100, 32'd0, 32'h00003344, 1'b0, 3, 0, 32'd0, 32'd0);
    do_req("lb1", 1'b0, 3'b000, 32'h101, 32'd0, 32'h00000033, 1'b0, 3, 0, 32'd0, 32'd0);
    do_req("sh",  1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'd0, 1'b0, 4, 1, 32'h100, 32'hBEEF3344);
    do_req("lw2", 1'b0, 3'b010, 32'h100, 32'd0, 32'hBEEF3344, 1'b0, 3, 0, 32'd0, 32'd0);
    do_req("sh_lo", 1'b1, 3'b001, 32'h100, 32'h0000CAFE, 32'd0, 1'b0, 4, 1, 32'h100, 32'hBEEFCAFE);

    do_req("err_lw",  1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0);
    do_req("err_sh",  1'b1, 3'b001, 32'h103, 32'h1, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0);
    do_req("err_011", 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0);
    do_req("err_sbu", 1'b1, 3'b100, 32'h100, 32'h5, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0);
    do_req("lw_after_err", 1'b0, 3'b010, 32'h100, 32'd0, 32'hBEEFCAFE, 1'b0, 3, 0, 32'd0, 32'd0);

    for (int i = 0; i < 4; i++) begin
      a = {22'd0, 8'($urandom_range(8'h41, 8'hFF)), 2'b00};
      d = $urandom;
      do_req("rnd_sw", 1'b1, 3'b010, a, d, 32'd0, 1'b0, 2, 1, a, d);
      do_req("rnd_lw", 1'b0, 3'b010, a, 32'd0, d, 1'b0, 3, 0, 32'd0, 32'd0);
    end

    // reset while an SB sits in CAPTURE
    w0 = write_cnt;
    drive_req(1'b1, 3'b000, 32'h100, 32'h77);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_cap_outs", {29'd0, req_ready, mem_wen, resp_valid}, 32'h4);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("rst_cap_quiet", {30'd0, req_ready, resp_valid}, 32'h2);
    end
    check("rst_cap_writes", write_cnt - w0, 32'd0);

    // reset during the write cycle of an SW
    w0 = write_cnt;
    drive_req(1'b1, 3'b010, 32'h104, 32'h12345678);
    @(negedge clock);
    check("sw_in_write", {31'd0, mem_wen}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_wr_wen", {31'd0, mem_wen}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("rst_wr_quiet", {31'd0, resp_valid}, 32'd0);
    end
    check("rst_wr_writes", write_cnt - w0, 32'd0);
    do_req("lw_post_rst", 1'b0, 3'b010, 32'h100, 32'd0, 32'hBEEFCAFE, 1'b0, 3, 0, 32'd0, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: WORD_LEN, 32, data and address width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit idle and accepting; a request is accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data; byte/half taken from the low bits.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 resp_error  output  1  misaligned address or illegal funct3; valid with resp_valid.
REQ-013 mem_addr  output  32  word-aligned address to data memory (addr[1:0] = 00).
REQ-014 mem_wdata  output  32  full-word write data.
REQ-015 mem_wen  output  1  word write enable; memory performs no read while high.
REQ-016 mem_rdata  input  32  memory read word, valid the cycle after mem_addr is presented with mem_wen = 0.

Function
REQ-017 States SHALL be: IDLE, READ, CAPTURE, WRITE, RESP; all outputs driven from registers or state, with no combinational req-to-mem path.
REQ-018 IDLE: req_ready = 1, mem_wen = 0; all other states: req_ready = 0, and req_valid is ignored.
REQ-019 On accept, the unit SHALL latch req_wen, req_funct3, req_addr and req_wdata, then go to:
- RESP with error if misaligned or illegal;
- WRITE for SW;
- READ for all loads and for SB/SH.
REQ-020 Misalignment rules:
- H/HU: addr[0] ≠ 0.
- W: addr[1:0] ≠ 00.
REQ-021 Illegal funct3: 011, 110, 111 for any access; 100 and 101 with req_wen = 1.
REQ-022 A request that errors SHALL issue no memory access.
REQ-023 READ: mem_addr = {addr[31:2], 00}, mem_wen = 0; next state is CAPTURE.
REQ-024 CAPTURE: the unit SHALL sample mem_rdata; loads go to RESP, SB/SH go to WRITE.
REQ-025 Byte lane k (k = addr[1:0]) is bits [8k+7:8k], little-endian; the half lane is selected by addr[1].
REQ-026 Load extraction:
- B/H: sign-extend.
- BU/HU: zero-extend.
- W: pass through unchanged.
REQ-027 SB/SH merge: the captured word with only the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0].
REQ-028 WRITE: mem_wen = 1 for exactly one cycle with mem_addr aligned and mem_wdata = the merged word (SW: req_wdata); next state is RESP.
REQ-029 RESP: resp_valid = 1 for one cycle with resp_rdata and resp_error; next state is IDLE.
- A new request can be accepted the cycle after RESP.
- resp_rdata and resp_error hold until the next RESP.
REQ-030 Latency, counted in cycles after the accept edge to the resp_valid cycle:
- error: 1.
- SW: 2.
- load: 3.
- SB/SH: 4.
REQ-031 Exactly one memory write SHALL occur per store, and none per load.

Reset
REQ-032 While reset is high, the unit SHALL immediately force:
- state IDLE, req_ready = 1;
- mem_wen = 0, resp_valid = 0, resp_error = 0;
- mem_addr, mem_wdata and resp_rdata = 0.
REQ-033 Reset mid-operation SHALL drop the pending request: no write and no response afterwards, including when asserted during WRITE, which truncates the write cycle.

Verification
REQ-034 Assert reset, then release -> every output holds its REQ-032 value; req_ready = 1.
REQ-035 SW addr 0x100, data 0xDEADBEEF -> cycle 1: mem_wen = 1, mem_addr = 0x100, mem_wdata = 0xDEADBEEF; cycle 2: resp_valid = 1, resp_error = 0.
REQ-036 SB addr 0x103, data 0x000000AA, memory word 0x11223344 -> one read of 0x100, then a single write of 0xAA223344 at cycle 3; resp_valid at cycle 4.
REQ-037 Memory word at 0x100 = 0x11803344 -> expected results:
- LB 0x102 -> 0xFFFFFF80.
- LBU 0x102 -> 0x00000080.
- LH 0x102 -> 0x00001180.
- LW 0x100 -> 0x11803344 at cycle 3.
REQ-038 Erroring requests -> resp_valid at cycle 1 with resp_error = 1, resp_rdata = 0, and mem_wen never asserted:
- LW 0x101.
- SH 0x103.
- funct3 = 011.
REQ-039 SB in progress; reset asserted during CAPTURE -> mem_wen stays 0, no resp_valid, and req_ready = 1 after release.
